// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core (incl. bge) over one shared valid/ready memory port
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit MEM_ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_BGE = 6'b000111, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
    FN_OR = 6'b100101, FN_SLT = 6'b101010;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    RTYPEEX, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
  } state_t;
  state_t state, state_n;
  logic [31:0] ir, a, b, aluout, mdr, simm, eff, alu_r;
  logic [31:0] rf [32];
  logic [5:0] op, funct;
  logic op_ok, fn_ok, bad, misal, taken;
  assign op = ir[31:26];
  assign funct = ir[5:0];
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign eff = a + simm;
  assign misal = MEM_ALIGN_CHECK && (eff[1:0] != 2'b00);
  assign op_ok = op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                 op == OP_BGE || op == OP_ADDI || op == OP_J;
  assign fn_ok = funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                 funct == FN_OR || funct == FN_SLT;
  assign bad = !op_ok || (op == OP_R && !fn_ok);
  assign taken = op == OP_BEQ ? a == b : $signed(a) >= $signed(b);
  assign alu_r = funct == FN_ADD ? a + b :
                 funct == FN_SUB ? a - b :
                 funct == FN_AND ? a & b :
                 funct == FN_OR  ? a | b : {31'b0, $signed(a) < $signed(b)};
  // Memory port is a pure decode of state so it stays stable through wait states and drops on reset.
  assign mem_req = state == FETCH || state == MEMREAD || state == MEMWRITE;
  assign mem_we = state == MEMWRITE;
  assign mem_addr = state == FETCH ? pc : (state == MEMREAD || state == MEMWRITE) ? aluout : 32'h0;
  assign mem_wdata = state == MEMWRITE ? b : 32'h0;
  assign retire = state == MEMWB || state == ALUWB || state == ADDIWB || state == BRANCH ||
                  state == JUMP || (state == MEMWRITE && mem_ready) ||
                  (state == DECODE && bad) || (state == MEMADR && misal);
  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Next-state sequencing per instruction class.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = FETCH;
      FETCH:    state_n = mem_ready ? DECODE : FETCH;
      DECODE:   state_n = bad ? FETCH : (op == OP_LW || op == OP_SW) ? MEMADR :
                          op == OP_R ? RTYPEEX : op == OP_ADDI ? ADDIEX : op == OP_J ? JUMP : BRANCH;
      MEMADR:   state_n = misal ? FETCH : op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  state_n = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_n = mem_ready ? FETCH : MEMWRITE;
      RTYPEEX:  state_n = ALUWB;
      ADDIEX:   state_n = ADDIWB;
      default:  state_n = FETCH;
    endcase
  end
  // Datapath registers: PC, IR, operand latches, ALU result, memory data.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      aluout <= '0;
      mdr <= '0;
    end else
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a <= rf[ir[25:21]];
          b <= rf[ir[20:16]];
          aluout <= pc + (simm << 2);
        end
        MEMADR, ADDIEX: aluout <= eff;
        MEMREAD: if (mem_ready) mdr <= mem_rdata;
        RTYPEEX: aluout <= alu_r;
        BRANCH: if (taken) pc <= aluout;
        JUMP: pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
  // Register file writeback; $0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (state == MEMWB && ir[20:16] != 5'd0) rf[ir[20:16]] <= mdr;
    else if (state == ADDIWB && ir[20:16] != 5'd0) rf[ir[20:16]] <= aluout;
    else if (state == ALUWB && ir[15:11] != 5'd0) rf[ir[15:11]] <= aluout;
  // Sticky illegal flag for bad encodings and misaligned accesses.
  always_ff @(posedge clk or posedge reset)
    if (reset) illegal <= 1'b0;
    else if ((state == DECODE && bad) || (state == MEMADR && misal)) illegal <= 1'b1;
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: scoreboard bench checking memory transactions, retire latency and reset behaviour
module tb_mips_multicycle;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_req, mem_we, mem_ready, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [31:0] mem [256];
  int waited = 0;
  int prog_sel = 0;
  int total = 0;
  int bad = 0;
  txn_t txq[$];
  int latq[$];

  mips_multicycle dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Read at 0x80 waits 3 cycles; write at 0x90 never completes (used to test reset mid-request).
  assign mem_ready = !(mem_req && ((mem_addr == 32'h80 && !mem_we && waited < 3) ||
                                   (mem_addr == 32'h90 && mem_we)));
  assign mem_rdata = mem[mem_addr[9:2]];

  function automatic logic [31:0] img(input int sel, input int w);
    if (sel == 0)
      case (w)
        0: return 32'h20010005;  1: return 32'h2002FFFD;  2: return 32'h00221820;
        3: return 32'h0041202A;  4: return 32'hAC030008;  5: return 32'hAC04000C;
        6: return 32'h8C050080;  7: return 32'hAC050084;  8: return 32'h1C410002;
        9: return 32'h1C220002;  10: return 32'h20060063; 11: return 32'h20060063;
        12: return 32'h10210001; 13: return 32'h20060063; 14: return 32'h08000040;
        32: return 32'hDEADBEEF; 64: return 32'hFC000000; 65: return 32'h00223800;
        66: return 32'h8C060006; 67: return 32'hAC070088; 68: return 32'hAC06008C;
        69: return 32'hAC020090;
        default: return 32'h0;
      endcase
    case (w)
      0: return 32'hAC040080; 1: return 32'hAC050084; 2: return 32'h08000002;
      32: return 32'hDEADBEEF;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk)
    if (reset) begin
      waited <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= img(prog_sel, i);
    end else begin
      if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;
      waited <= (mem_req && !mem_ready) ? waited + 1 : 0;
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ex_rd(input logic [31:0] a);
    txq.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
    txq.push_back('{1'b1, a, d});
  endtask

  // Monitor: pops expected transactions/latencies whenever the DUT completes one.
  initial begin
    txn_t e;
    logic sp = 1'b0;
    logic pv_we = 1'b0;
    logic [31:0] pv_addr = '0, pv_wdata = '0;
    int cyc = 0;
    int l;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
        sp = 1'b0;
      end else begin
        cyc++;
        if (sp) begin
          check("stable_ctl", {30'b0, mem_req, mem_we}, {30'b0, 1'b1, pv_we});
          check("stable_addr", mem_addr, pv_addr);
          check("stable_wdata", mem_wdata, pv_wdata);
        end
        if (mem_req && mem_ready) begin
          total++;
          if (txq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_txn: got we=%b addr=%h with nothing expected", mem_we, mem_addr);
          end else begin
            e = txq.pop_front();
            check("txn_we", {31'b0, mem_we}, {31'b0, e.we});
            check("txn_addr", mem_addr, e.addr);
            if (e.we) check("txn_wdata", mem_wdata, e.data);
          end
        end
        if (retire) begin
          total++;
          if (latq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_retire: got retire at pc=%h with nothing expected", pc);
          end else begin
            l = latq.pop_front();
            check("latency", cyc, l);
          end
          cyc = 0;
        end
        sp = mem_req && !mem_ready;
        pv_we = mem_we;
        pv_addr = mem_addr;
        pv_wdata = mem_wdata;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  // Stimulus: program images, expected transaction stream, reset scenarios.
  initial begin
    prog_sel = 0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_ctl", {28'b0, mem_req, mem_we, retire, illegal}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    ex_rd(32'h00); latq.push_back(4);
    ex_rd(32'h04); latq.push_back(4);
    ex_rd(32'h08); latq.push_back(4);
    ex_rd(32'h0C); latq.push_back(4);
    ex_rd(32'h10); ex_wr(32'h08, 32'd2); latq.push_back(4);
    ex_rd(32'h14); ex_wr(32'h0C, 32'd1); latq.push_back(4);
    ex_rd(32'h18); ex_rd(32'h80); latq.push_back(8);
    ex_rd(32'h1C); ex_wr(32'h84, 32'hDEADBEEF); latq.push_back(4);
    ex_rd(32'h20); latq.push_back(3);
    ex_rd(32'h24); latq.push_back(3);
    ex_rd(32'h30); latq.push_back(3);
    ex_rd(32'h38); latq.push_back(3);
    ex_rd(32'h100); latq.push_back(2);
    ex_rd(32'h104); latq.push_back(2);
    ex_rd(32'h108); latq.push_back(3);
    ex_rd(32'h10C); ex_wr(32'h88, 32'h0); latq.push_back(4);
    ex_rd(32'h110); ex_wr(32'h8C, 32'h0); latq.push_back(4);
    ex_rd(32'h114);
    #2 reset = 1'b0;
    #1 check("idle_req", {31'b0, mem_req}, 32'h0);
    @(posedge clk);
    #1 check("first_fetch_ctl", {30'b0, mem_req, mem_we}, 32'h2);
    check("first_fetch_addr", mem_addr, 32'h0);
    for (int i = 0; i < 400 && !(mem_req && mem_addr == 32'h100); i++) @(negedge clk);
    check("reach_0x100", mem_addr, 32'h100);
    check("illegal_before", {31'b0, illegal}, 32'h0);
    for (int i = 0; i < 400 && !(mem_req && mem_we && mem_addr == 32'h90); i++) @(negedge clk);
    check("stalled_sw_addr", mem_addr, 32'h90);
    check("illegal_sticky", {31'b0, illegal}, 32'h1);
    check("prog1_txq_left", txq.size(), 32'h0);
    check("prog1_lat_left", latq.size(), 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    prog_sel = 1;
    #1 check("abort_req", {31'b0, mem_req}, 32'h0);
    check("abort_pc", pc, 32'h0);
    check("abort_ctl", {29'b0, mem_we, retire, illegal}, 32'h0);
    check("abort_addr", mem_addr, 32'h0);
    ex_rd(32'h0); ex_wr(32'h80, 32'h0); latq.push_back(4);
    ex_rd(32'h4); ex_wr(32'h84, 32'h0); latq.push_back(4);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 200 && (txq.size() != 0 || latq.size() != 0); i++) @(posedge clk);
    check("prog2_txq_left", txq.size(), 32'h0);
    check("prog2_lat_left", latq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
